router_pkt_tx: RTL

//  Packet source for the 1x3 router input port. Buffers one user payload, then transmits it
//  as header {len[5:0],addr[1:0]}, payload bytes (pkt_valid=1), then parity byte (pkt_valid=0).

---
 rtl/router_pkt_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// Packet source for one router input port: buffers a payload from the host, then sends
// header, payload and parity under router busy flow control and reports the router's verdict.
module router_pkt_tx #(
  parameter int IFG     = 2,
  parameter int ERR_WIN = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  dest_addr,
  input  logic [5:0]  payload_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        corrupt_parity,
  input  logic        busy,
  input  logic        error,
  output logic [7:0]  pkt_data,
  output logic        pkt_valid,
  output logic        tx_active,
  output logic        tx_done,
  output logic        tx_err,
  output logic [15:0] pkt_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HDR, S_PLD, S_PAR, S_CHK, S_GAP} state_t;

  localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;
  localparam int WW = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(IFG - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(ERR_WIN - 1);

  state_t          state_q, state_n;
  logic [1:0]      addr_q;
  logic [5:0]      len_q;
  logic            corrupt_q;
  logic [7:0]      acc_q;
  logic [5:0]      wr_idx_q;
  logic [5:0]      rd_idx_q;
  logic [WW-1:0]   win_q;
  logic [GW-1:0]   gap_q;
  logic            err_q;
  logic [7:0]      buf_mem [0:63];

  logic start_legal, load_last, pld_last, win_last, gap_last, chk_err;

  assign start_legal = start && (dest_addr != 2'd3) && (payload_len != 6'd0);
  assign load_last   = wr_valid && (wr_idx_q == len_q - 6'd1);
  assign pld_last    = (rd_idx_q == len_q);
  assign win_last    = (win_q == WIN_LAST);
  assign gap_last    = (gap_q == GAP_LAST);
  assign chk_err     = err_q | error;
  assign wr_ready    = (state_q == S_LOAD);

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_n;
  end

  // NOTE: state_n is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE: if (start_legal) state_n = S_LOAD;
      S_LOAD: if (load_last)   state_n = S_HDR;
      S_HDR:  if (!busy)       state_n = S_PLD;
      S_PLD:  if (!busy && pld_last) state_n = S_PAR;
      S_PAR:  if (!busy)       state_n = S_CHK;
      S_CHK:  if (win_last)    state_n = (IFG == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (gap_last)    state_n = S_IDLE;
      default:                 state_n = S_IDLE;
    endcase
  end

  // NOTE: payload storage carries no reset; every byte is written in LOAD before it is read.
  always_ff @(posedge clock) begin
    if (state_q == S_LOAD && wr_valid) buf_mem[wr_idx_q] <= wr_data;
  end

  // NOTE: all state here updates with <= so every branch sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pkt_data  <= 8'd0;
      pkt_valid <= 1'b0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      pkt_cnt   <= 16'd0;
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      corrupt_q <= 1'b0;
      acc_q     <= 8'd0;
      wr_idx_q  <= 6'd0;
      rd_idx_q  <= 6'd0;
      win_q     <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      tx_done   <= 1'b0;
      tx_active <= (state_n != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          if (start_legal) begin
            addr_q    <= dest_addr;
            len_q     <= payload_len;
            corrupt_q <= corrupt_parity;
            tx_err    <= 1'b0;
            acc_q     <= {payload_len, dest_addr};
            wr_idx_q  <= 6'd0;
          end else if (start) begin
            tx_done <= 1'b1;
            tx_err  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (wr_valid) begin
            acc_q    <= acc_q ^ wr_data;
            wr_idx_q <= wr_idx_q + 6'd1;
            if (load_last) begin
              pkt_data  <= {len_q, addr_q};
              pkt_valid <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (!busy) begin
            pkt_data <= buf_mem[0];
            rd_idx_q <= 6'd1;
          end
        end
        S_PLD: begin
          if (!busy) begin
            if (pld_last) begin
              pkt_data  <= corrupt_q ? ~acc_q : acc_q;
              pkt_valid <= 1'b0;
            end else begin
              pkt_data <= buf_mem[rd_idx_q];
              rd_idx_q <= rd_idx_q + 6'd1;
            end
          end
        end
        S_PAR: begin
          if (!busy) begin
            pkt_data <= 8'd0;
            win_q    <= '0;
            err_q    <= 1'b0;
          end
        end
        S_CHK: begin
          err_q <= chk_err;
          win_q <= win_q + 1'b1;
          if (win_last) begin
            tx_done <= 1'b1;
            tx_err  <= chk_err;
            if (!chk_err) pkt_cnt <= pkt_cnt + 16'd1;
            gap_q <= '0;
          end
        end
        S_GAP: gap_q <= gap_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
